// File: rtl/core_ex_alu_arb_pkg.sv
// Shared core widths and the stage entry types used by the EX ALU arbiter.
// One-hot ALU instruction bits: op select in [9:0], operand/compare modifiers above.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_ALU_INST_WIDTH
`define CORE_ALU_INST_WIDTH   13
`define CORE_ALU_INST_ADD     0
`define CORE_ALU_INST_SUB     1
`define CORE_ALU_INST_AND     2
`define CORE_ALU_INST_OR      3
`define CORE_ALU_INST_XOR     4
`define CORE_ALU_INST_SLL     5
`define CORE_ALU_INST_SRL     6
`define CORE_ALU_INST_SRA     7
`define CORE_ALU_INST_SLT     8
`define CORE_ALU_INST_PASS    9
`define CORE_ALU_INST_OP1_PC  10
`define CORE_ALU_INST_OP2_IMM 11
`define CORE_ALU_INST_CMP_U   12
`endif

package core_ex_alu_arb_pkg;

  typedef logic [`CORE_ALU_INST_WIDTH-1:0] alu_inst_t;
  typedef logic [`CORE_XLEN-1:0]           xlen_t;

  typedef struct packed {
    alu_inst_t inst;
    xlen_t     rs1;
    xlen_t     rs2;
    xlen_t     pc;
    xlen_t     imm;
    logic      owner;
  } stage_a_t;

  typedef struct packed {
    xlen_t result;
    logic  zero;
    logic  less;
    logic  owner;
  } stage_b_t;

endpackage

// File: rtl/core_ex_alu.sv
// Combinational EX ALU: one-hot op select, operand muxing and compare flags.
module core_ex_alu
  import core_ex_alu_arb_pkg::*;
(
  input  alu_inst_t alu_inst,
  input  xlen_t     rs1,
  input  xlen_t     rs2,
  input  xlen_t     pc,
  input  xlen_t     imm,
  output xlen_t     result,
  output logic      zero_flag,
  output logic      less_flag
);

  localparam int SHW = $clog2(`CORE_XLEN);

  xlen_t                  op1;
  xlen_t                  op2;
  logic signed [`CORE_XLEN-1:0] op1_s;
  logic [SHW-1:0]         shamt;
  xlen_t                  sra_res;
  xlen_t                  slt_res;

  assign op1   = alu_inst[`CORE_ALU_INST_OP1_PC]  ? pc  : rs1;
  assign op2   = alu_inst[`CORE_ALU_INST_OP2_IMM] ? imm : rs2;
  assign op1_s = op1;
  assign shamt = op2[SHW-1:0];

  assign zero_flag = (op1 == op2);
  assign less_flag = alu_inst[`CORE_ALU_INST_CMP_U] ? (op1 < op2)
                                                    : ($signed(op1) < $signed(op2));

  // Kept as separate signals so the arithmetic shift stays signed.
  assign sra_res = op1_s >>> shamt;
  assign slt_res = {{(`CORE_XLEN-1){1'b0}}, less_flag};

  assign result = ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_ADD]}}  & (op1 + op2))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_SUB]}}  & (op1 - op2))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_AND]}}  & (op1 & op2))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_OR]}}   & (op1 | op2))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_XOR]}}  & (op1 ^ op2))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_SLL]}}  & (op1 << shamt))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_SRL]}}  & (op1 >> shamt))
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_SRA]}}  & sra_res)
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_SLT]}}  & slt_res)
                | ({`CORE_XLEN{alu_inst[`CORE_ALU_INST_PASS]}} & op2);

endmodule

// File: rtl/core_ex_alu_arb.sv
// Two-requester front end for the EX ALU: arbiter, operand stage A, result stage B.
// In-order, at most two operations in flight, flush and reset drop everything.
module core_ex_alu_arb
  import core_ex_alu_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [1:0]                       req_valid,
  output logic [1:0]                       req_ready,
  input  logic [2*`CORE_ALU_INST_WIDTH-1:0] req_alu_inst,
  input  logic [2*`CORE_XLEN-1:0]          req_rs1,
  input  logic [2*`CORE_XLEN-1:0]          req_rs2,
  input  logic [2*`CORE_XLEN-1:0]          req_pc,
  input  logic [2*`CORE_XLEN-1:0]          req_imm,
  input  logic                             flush,
  output logic [1:0]                       rsp_valid,
  input  logic [1:0]                       rsp_ready,
  output logic [`CORE_XLEN-1:0]            rsp_result,
  output logic                             rsp_zero,
  output logic                             rsp_less,
  output logic                             busy
);

  localparam int IW = `CORE_ALU_INST_WIDTH;
  localparam int XW = `CORE_XLEN;

  logic     a_valid;
  logic     b_valid;
  logic     last_grant;
  stage_a_t a_q;
  stage_a_t a_next;
  stage_b_t b_q;

  logic       b_consume;
  logic       a_advance;
  logic       a_can_accept;
  logic       gnt_id;
  logic [1:0] gnt_vec;
  logic       accept;

  xlen_t alu_result;
  logic  alu_zero;
  logic  alu_less;

  assign b_consume    = b_valid & rsp_ready[b_q.owner];
  assign a_advance    = a_valid & (~b_valid | b_consume);
  assign a_can_accept = ~a_valid | a_advance;

  // On a tie round-robin favours whoever was not accepted last.
  always_comb begin
    gnt_id = 1'b0;
    if (req_valid == 2'b11) begin
      gnt_id = RR_EN ? ~last_grant : 1'b0;
    end else begin
      gnt_id = req_valid[1] & ~req_valid[0];
    end
  end

  assign gnt_vec   = req_valid & (gnt_id ? 2'b10 : 2'b01);
  assign req_ready = (rst_n & a_can_accept & ~flush) ? gnt_vec : 2'b00;
  assign accept    = |req_ready;

  always_comb begin
    a_next.inst  = gnt_id ? req_alu_inst[2*IW-1 -: IW] : req_alu_inst[IW-1:0];
    a_next.rs1   = gnt_id ? req_rs1[2*XW-1 -: XW]      : req_rs1[XW-1:0];
    a_next.rs2   = gnt_id ? req_rs2[2*XW-1 -: XW]      : req_rs2[XW-1:0];
    a_next.pc    = gnt_id ? req_pc[2*XW-1 -: XW]       : req_pc[XW-1:0];
    a_next.imm   = gnt_id ? req_imm[2*XW-1 -: XW]      : req_imm[XW-1:0];
    a_next.owner = gnt_id;
  end

  core_ex_alu u_alu (
    .alu_inst  (a_q.inst),
    .rs1       (a_q.rs1),
    .rs2       (a_q.rs2),
    .pc        (a_q.pc),
    .imm       (a_q.imm),
    .result    (alu_result),
    .zero_flag (alu_zero),
    .less_flag (alu_less)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid    <= 1'b0;
      b_valid    <= 1'b0;
      last_grant <= 1'b1;
    end else if (flush) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
    end else begin
      if (accept) begin
        a_valid    <= 1'b1;
        last_grant <= gnt_id;
      end else if (a_advance) begin
        a_valid <= 1'b0;
      end
      if (a_advance) begin
        b_valid <= 1'b1;
      end else if (b_consume) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Payload registers carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a_next;
    end
    if (a_advance) begin
      b_q <= '{result: alu_result, zero: alu_zero, less: alu_less, owner: a_q.owner};
    end
  end

  assign rsp_valid  = {b_valid & b_q.owner, b_valid & ~b_q.owner};
  assign rsp_result = b_q.result;
  assign rsp_zero   = b_q.zero;
  assign rsp_less   = b_q.less;
  assign busy       = a_valid | b_valid;

endmodule

// File: tb/tb_core_ex_alu_arb.sv
// Self-checking bench for core_ex_alu_arb: vector table through a scoreboard,
// plus directed sequences for arbitration, stall, flush and reset.
`ifndef CORE_XLEN
`define CORE_XLEN 32
`endif
`ifndef CORE_ALU_INST_WIDTH
`define CORE_ALU_INST_WIDTH   13
`define CORE_ALU_INST_ADD     0
`define CORE_ALU_INST_SUB     1
`define CORE_ALU_INST_AND     2
`define CORE_ALU_INST_OR      3
`define CORE_ALU_INST_XOR     4
`define CORE_ALU_INST_SLL     5
`define CORE_ALU_INST_SRL     6
`define CORE_ALU_INST_SRA     7
`define CORE_ALU_INST_SLT     8
`define CORE_ALU_INST_PASS    9
`define CORE_ALU_INST_OP1_PC  10
`define CORE_ALU_INST_OP2_IMM 11
`define CORE_ALU_INST_CMP_U   12
`endif

module tb_core_ex_alu_arb;

  localparam int IW = `CORE_ALU_INST_WIDTH;
  localparam int XW = `CORE_XLEN;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      rsp_ready = 2'b00;
  logic            flush = 1'b0;
  logic [2*IW-1:0] req_alu_inst = '0;
  logic [2*XW-1:0] req_rs1 = '0;
  logic [2*XW-1:0] req_rs2 = '0;
  logic [2*XW-1:0] req_pc = '0;
  logic [2*XW-1:0] req_imm = '0;

  logic [1:0]    req_ready, rsp_valid;
  logic [XW-1:0] rsp_result;
  logic          rsp_zero, rsp_less, busy;
  logic [1:0]    fp_req_ready, fp_rsp_valid;
  logic [XW-1:0] fp_rsp_result;
  logic          fp_rsp_zero, fp_rsp_less, fp_busy;

  core_ex_alu_arb #(.RR_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_inst(req_alu_inst), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_imm(req_imm), .flush(flush), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .rsp_less(rsp_less), .busy(busy)
  );

  core_ex_alu_arb #(.RR_EN(1'b0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_alu_inst(req_alu_inst), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_pc(req_pc), .req_imm(req_imm), .flush(flush), .rsp_valid(fp_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(fp_rsp_result), .rsp_zero(fp_rsp_zero),
    .rsp_less(fp_rsp_less), .busy(fp_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] inst;
    logic [XW-1:0] rs1, rs2, pc, imm, res;
    logic          zero, less;
  } vec_t;

  typedef struct packed {
    logic          owner;
    logic [XW-1:0] res;
    logic          zero;
    logic          less;
  } exp_t;

  vec_t vec [14];
  exp_t sb [$];
  int   pend0 [$];
  int   pend1 [$];
  exp_t drv_exp [2];
  logic [1:0] took = 2'b00;
  int checks = 0;
  int errors = 0;
  int acc_count = 0;

  function automatic logic [IW-1:0] op(input int idx);
    logic [IW-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input int v);
    req_alu_inst[i*IW +: IW] = vec[v].inst;
    req_rs1[i*XW +: XW]      = vec[v].rs1;
    req_rs2[i*XW +: XW]      = vec[v].rs2;
    req_pc[i*XW +: XW]       = vec[v].pc;
    req_imm[i*XW +: XW]      = vec[v].imm;
    drv_exp[i] = '{owner: (i == 1), res: vec[v].res, zero: vec[v].zero, less: vec[v].less};
  endtask

  task automatic update_drive();
    if (took[0]) void'(pend0.pop_front());
    if (took[1]) void'(pend1.pop_front());
    took = 2'b00;
    if (pend0.size() > 0) begin req_valid[0] = 1'b1; set_req(0, pend0[0]); end
    else req_valid[0] = 1'b0;
    if (pend1.size() > 0) begin req_valid[1] = 1'b1; set_req(1, pend1[0]); end
    else req_valid[1] = 1'b0;
  endtask

  // Sampled just before the active edge: records handshakes that edge will perform.
  task automatic monitor();
    exp_t got;
    exp_t want;
    if (!rst_n || flush) begin
      sb.delete();
    end else begin
      chk("req_ready_onehot", ($countones(req_ready) <= 1), 1);
      if (rsp_valid != 2'b00) begin
        chk("rsp_valid_onehot", $countones(rsp_valid), 1);
        if (rsp_ready[rsp_valid[1]]) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", rsp_valid, 0);
          end else begin
            want = sb.pop_front();
            got  = '{owner: rsp_valid[1], res: rsp_result, zero: rsp_zero, less: rsp_less};
            chk("rsp_data", got, want);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          took[i] = 1'b1;
          sb.push_back(drv_exp[i]);
          acc_count++;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    monitor();
    @(posedge clk);
    #1;
    update_drive();
    @(negedge clk);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((busy || sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    chk(name, (busy || sb.size() != 0 || pend0.size() != 0 || pend1.size() != 0), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    vec[0]  = '{op(`CORE_ALU_INST_ADD), 5, 7, 0, 0, 12, 0, 1};
    vec[1]  = '{op(`CORE_ALU_INST_ADD), 1, 1, 0, 0, 2, 1, 0};
    vec[2]  = '{op(`CORE_ALU_INST_SUB), 9, 4, 0, 0, 5, 0, 0};
    vec[3]  = '{op(`CORE_ALU_INST_AND), 32'hF0F0, 32'hFF00, 0, 0, 32'hF000, 0, 1};
    vec[4]  = '{op(`CORE_ALU_INST_OR), 32'hF0, 32'h0F, 0, 0, 32'hFF, 0, 0};
    vec[5]  = '{op(`CORE_ALU_INST_XOR), 32'hAAAA_AAAA, 32'hFFFF_FFFF, 0, 0, 32'h5555_5555, 0, 1};
    vec[6]  = '{op(`CORE_ALU_INST_SLL), 1, 31, 0, 0, 32'h8000_0000, 0, 1};
    vec[7]  = '{op(`CORE_ALU_INST_SRA), 32'h8000_0000, 4, 0, 0, 32'hF800_0000, 0, 1};
    vec[8]  = '{op(`CORE_ALU_INST_SRL) | op(`CORE_ALU_INST_CMP_U), 32'h8000_0000, 4, 0, 0, 32'h0800_0000, 0, 0};
    vec[9]  = '{op(`CORE_ALU_INST_SLT), 32'hFFFF_FFFF, 1, 0, 0, 1, 0, 1};
    vec[10] = '{op(`CORE_ALU_INST_SLT) | op(`CORE_ALU_INST_CMP_U), 32'hFFFF_FFFF, 1, 0, 0, 0, 0, 0};
    vec[11] = '{op(`CORE_ALU_INST_ADD) | op(`CORE_ALU_INST_OP1_PC) | op(`CORE_ALU_INST_OP2_IMM),
                32'hDEAD, 32'hBEEF, 32'h1000, 32'h24, 32'h1024, 0, 0};
    vec[12] = '{op(`CORE_ALU_INST_PASS) | op(`CORE_ALU_INST_OP2_IMM), 0, 5, 0, 32'h1234_5000, 32'h1234_5000, 0, 1};
    vec[13] = '{op(`CORE_ALU_INST_SUB), 3, 3, 0, 0, 0, 1, 0};

    // Reset state, with both requesters already asserting.
    @(negedge clk);
    rsp_ready = 2'b11;
    pend0.push_back(1);
    pend1.push_back(2);
    update_drive();
    #1;
    chk("reset_req_ready", req_ready, 2'b00);
    chk("reset_rsp_valid", rsp_valid, 2'b00);
    chk("reset_busy", busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("rr_first_tie", req_ready, 2'b01);
    tick();
    chk("rr_second", req_ready, 2'b10);
    tick();
    chk("rr_rsp0_valid", rsp_valid, 2'b01);
    tick();
    chk("rr_rsp1_valid", rsp_valid, 2'b10);
    tick();
    chk("rr_idle_busy", busy, 0);

    // Single ADD, latency.
    pend0.push_back(0);
    update_drive();
    #1;
    chk("add_req_ready", req_ready, 2'b01);
    tick();
    chk("add_not_early", rsp_valid, 2'b00);
    tick();
    chk("add_rsp_valid", rsp_valid, 2'b01);
    chk("add_result", rsp_result, 12);
    chk("add_zero", rsp_zero, 0);
    chk("add_less", rsp_less, 1);
    drain("add_drain", 10);

    // Vector table, alternating requesters, full throughput.
    for (int i = 0; i < 14; i++) begin
      if (i % 2 == 0) pend0.push_back(i);
      else pend1.push_back(i);
    end
    update_drive();
    acc0 = acc_count;
    for (int i = 0; i < 14; i++) tick();
    chk("throughput", acc_count - acc0, 14);
    drain("table_drain", 20);

    // Backpressure: three queued, only two fit.
    rsp_ready = 2'b00;
    pend0.push_back(3);
    pend0.push_back(4);
    pend1.push_back(5);
    update_drive();
    acc0 = acc_count;
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_req_ready", req_ready, 2'b00);
      chk("stall_rsp_valid", rsp_valid, sb[0].owner ? 2'b10 : 2'b01);
      chk("stall_rsp_result", rsp_result, sb[0].res);
      chk("stall_busy", busy, 1);
    end
    chk("stall_accepted", acc_count - acc0, 2);
    rsp_ready = 2'b11;
    drain("stall_drain", 20);

    // Flush with both stages full and a new request pending.
    rsp_ready = 2'b00;
    pend0.push_back(6);
    pend1.push_back(7);
    update_drive();
    tick();
    tick();
    chk("flush_pre_busy", busy, 1);
    pend0.push_back(8);
    update_drive();
    flush = 1'b1;
    #1;
    chk("flush_no_accept", req_ready, 2'b00);
    tick();
    flush = 1'b0;
    chk("flush_rsp_valid", rsp_valid, 2'b00);
    chk("flush_busy", busy, 0);
    #1;
    chk("flush_next_accept", req_ready, 2'b01);
    rsp_ready = 2'b11;
    drain("flush_drain", 20);

    // Fixed priority instance never grants requester 1 on a tie.
    pend0 = '{0, 1, 2, 3, 13};
    pend1 = '{9, 10, 11, 12, 4};
    update_drive();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("fp_req_ready", fp_req_ready, 2'b01);
      tick();
    end
    drain("fp_drain", 30);

    // Asynchronous reset between edges with both stages full.
    rsp_ready = 2'b00;
    pend0.push_back(9);
    pend1.push_back(10);
    update_drive();
    tick();
    tick();
    chk("rst_pre_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", rsp_valid, 2'b00);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 2'b00);
    tick();
    tick();
    rst_n = 1'b1;
    rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_no_rsp", rsp_valid, 2'b00);
    end

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_ex_alu_arb.md
CORE_EX_ALU_ARB -- requirements
Module: core_ex_alu_arb

Interface
REQ-001 SHALL have parameter RR_EN, default 1: 1 = round-robin arbitration, 0 = fixed priority with requester 0 highest.
REQ-002 SHALL have port clk, input, 1: the single clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port req_valid, input, 2: per-requester operation request; bit i = requester i.
REQ-005 SHALL have port req_ready, output, 2: per-requester accept.
REQ-006 SHALL have port req_alu_inst, input, 2*`CORE_ALU_INST_WIDTH: one-hot ALU op/operand-select bus; requester i in slice [i*W +: W].
REQ-007 SHALL have port req_rs1, input, 2*`CORE_XLEN: rs1 operand per requester, same slicing.
REQ-008 SHALL have port req_rs2, input, 2*`CORE_XLEN: rs2 operand per requester.
REQ-009 SHALL have port req_pc, input, 2*`CORE_XLEN: pc operand per requester.
REQ-010 SHALL have port req_imm, input, 2*`CORE_XLEN: immediate per requester.
REQ-011 SHALL have port flush, input, 1: discards all in-flight operations.
REQ-012 SHALL have port rsp_valid, output, 2: result valid, only the bit of the owning requester set.
REQ-013 SHALL have port rsp_ready, input, 2: per-requester result accept.
REQ-014 SHALL have port rsp_result, output, `CORE_XLEN: registered ALU result.
REQ-015 SHALL have port rsp_zero, output, 1: registered zero_flag (op1 == op2).
REQ-016 SHALL have port rsp_less, output, 1: registered less_flag (unsigned if CMP_U set, else signed).
REQ-017 SHALL have port busy, output, 1: high while either pipeline stage holds a valid entry.

Function
REQ-018 Two stages SHALL exist: stage A = operand register (inst, rs1, rs2, pc, imm, owner); stage B = result register (result, zero, less, owner).
REQ-019 Stage A SHALL be able to accept when it is empty, or when it is full and advancing in the same cycle.
REQ-020 Stage A SHALL advance to stage B when B is empty or B is consumed in the same cycle.
REQ-021 B SHALL be consumed when rsp_valid[owner] & rsp_ready[owner].
REQ-022 At most one req_ready bit SHALL be high per cycle: the granted requester's, and only when A can accept and flush=0.
REQ-023 req_ready MAY depend combinationally on req_valid; a requester SHALL hold valid and payload stable until accepted.
REQ-024 Arbitration with RR_EN=1: a single valid request SHALL win; on a tie the requester not granted last SHALL win.
REQ-025 The last-grant pointer SHALL update only on acceptance; its reset value SHALL be 1, so requester 0 wins the first tie.
REQ-026 Arbitration with RR_EN=0: requester 0 SHALL always win ties.
REQ-027 Latency SHALL be 2 cycles: accept at edge N, rsp_valid high after edge N+1.
REQ-028 Throughput SHALL be 1 operation per cycle while rsp_ready of each owner is held high.
REQ-029 Results SHALL be returned in acceptance order; at most 2 operations SHALL be in flight.
REQ-030 With B full and not consumed, B and its outputs SHALL hold stable, A SHALL hold, and req_ready SHALL be 00 once A is full.
REQ-031 flush=1 SHALL clear A and B valid at the next edge, accept nothing that cycle, and leave the arbitration pointer unchanged.
REQ-032 flush SHALL take precedence over simultaneous consumption and advancement.
REQ-033 The ALU SHALL evaluate stage A contents combinationally; its outputs SHALL be captured into B only on advancement.

Reset
REQ-034 On rst_n low, A and B valid SHALL clear immediately: rsp_valid=00, req_ready=00, busy=0, pointer=1. Data registers need not reset.
REQ-035 Reset mid-operation SHALL drop all in-flight operations with no response issued after release.

Structure
REQ-036 Widths SHALL come from the shared `CORE_XLEN / `CORE_ALU_INST_* defines; no new package constants are required.
REQ-037 The block SHALL instantiate exactly one core_ex_alu as its sub-module; the arbiter and the two stages SHALL be local logic.

Verification
REQ-038 req0 ADD rs1=5 rs2=7, rsp_ready=11 -> rsp_valid=01 two cycles after accept, rsp_result=12, zero=0, less=1.
REQ-039 Both valid from reset, RR_EN=1, ADD 1+1 / SUB 9-4 -> req0 accepted first, req1 next cycle; responses 2 then 5 on consecutive cycles.
REQ-040 rsp_ready=00 for 4 cycles with 3 requests queued -> 2 accepted, req_ready=00, outputs stable; first result appears on release.
REQ-041 flush with A and B full -> rsp_valid=00 and busy=0 next cycle; a request valid during the flush cycle is accepted the cycle after.
REQ-042 RR_EN=0, both valid continuously for 5 cycles -> req_ready=01 every cycle; requester 1 is never granted.
REQ-043 rst_n asserted asynchronously between edges with both stages full -> rsp_valid=00 immediately; no response after release.
